// File: rtl/shift_add_multiplier_8bit.sv
// Unsigned 8x8->16 shift-and-add multiplier built on an 8-bit carry-look-ahead adder; optional ZERO_SKIP_EN.
// Latency: 9 cycles from the start edge to done (1 cycle for a zero operand when ZERO_SKIP_EN is defined).
// Backpressure: none; start is only accepted in IDLE or DONE and ignored while busy.

module Carry_Look_Ahead_Adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;
    logic       prop_run;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain.
    always_comb begin
        carry    = '0;
        prop_run = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i];
            prop_run   = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (prop_run & gen[j]);
                prop_run   = prop_run & prop[j];
            end
            carry[i+1] = carry[i+1] | (prop_run & cin);
        end
    end

    assign sum  = prop ^ carry[7:0];
    assign cout = carry[8];
endmodule

module shift_add_multiplier_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   p_next;
    logic [WIDTH-1:0]   q_next;

    assign add_b = q_q[0] ? m_q : '0;

    Carry_Look_Ahead_Adder_8bit u_cla (
        .a    (p_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {cout,sum,Q} >> 1: the adder carry lands in P's MSB, the sum LSB enters Q.
    assign p_next = {add_cout, add_sum[WIDTH-1:1]};
    assign q_next = {add_sum[0], q_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        state_d   = S_DONE;
                        product_d = '0;
                    end
`endif
                end
            end
            S_CALC: begin
                p_d   = p_next;
                q_d   = q_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    product_d = {p_next, q_next};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Directed bench for shift_add_multiplier_8bit: hand-computed products, latency and handshake checks.
module tb_shift_add_multiplier_8bit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total;
    int bad;
    int overlap;

    shift_add_multiplier_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse; returns edges from the start edge to the first done sample.
    task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                           input int exp_lat, input int exp_busy, input string tag);
        int lat;
        int bcnt;
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y;
        lat = 1; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, bcnt, exp_busy);
        chk({tag, "_prod"}, product, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int lat;
        int dcnt;
        total = 0; bad = 0; overlap = 0;
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_prod", product, 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_mul(8'd3,   8'd5,   16'd15,   9, 8, "m3x5");
        run_mul(8'd255, 8'd255, 16'hFE01, 9, 8, "m255x255");
        run_mul(8'd128, 8'd2,   16'h0100, 9, 8, "m128x2");
        run_mul(8'd1,   8'd255, 16'h00FF, 9, 8, "m1x255");
        run_mul(8'd13,  8'd11,  16'd143,  9, 8, "m13x11");
        run_mul(8'd200, 8'd3,   16'd600,  9, 8, "m200x3");
`ifdef ZERO_SKIP_EN
        run_mul(8'd0,   8'd200, 16'h0000, 1, 0, "zero");
`else
        run_mul(8'd0,   8'd200, 16'h0000, 9, 8, "zero");
`endif

        // Start pulsed during CALC must be ignored.
        a = 8'd10; b = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; dcnt = 0;
        repeat (3) begin @(negedge clk); lat++; end
        a = 8'd7; b = 8'd7; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0; a = 8'd0; b = 8'd0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("ign_lat", lat, 9);
        chk("ign_prod", product, 16'd100);
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("ign_pulses", dcnt, 1);

        // Start held high: second operation loads at the DONE cycle.
        a = 8'd2; b = 8'd3; start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("b2b_lat1", lat, 9);
        chk("b2b_prod1", product, 16'd6);
        a = 8'd4; b = 8'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("b2b_lat2", lat, 9);
        chk("b2b_prod2", product, 16'd20);
        @(negedge clk);

        // Asynchronous reset during CALC aborts the operation.
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_prod", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_nodone", dcnt, 0);
        chk("abort_prod_idle", product, 0);

        chk("busy_done_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier_8bit.md
Name: shift_add_multiplier_8bit

Overview:
- Multi-cycle unsigned 8x8 -> 16-bit multiplier, shift-and-add.
- Sits directly on top of the existing 8-bit carry-look-ahead adder stage: it sequences operands into one instance of Carry_Look_Ahead_Adder_8bit every cycle and consumes its sum/cout.
- start/busy/done handshake, for the datapath labs that need a product without a combinational array multiplier.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported because the adder instance is fixed at 8 bits. Counter and product widths derive from it.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk in IDLE or DONE only
- a  input  8  multiplicand; captured when start is accepted
- b  input  8  multiplier; captured when start is accepted
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse, high exactly while in DONE
- product  output  16  result; valid from DONE and held until the next accepted start

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - On rst_n=0, immediately: state=IDLE, busy=0, done=0, product=16'h0000, iteration counter=0, internal operand registers=0.
- State machine: IDLE, CALC, DONE.
  - IDLE, start=1: load M<=a, Q<=b, P<=8'h00, cnt<=0; go to CALC. IDLE, start=0: stay.
  - CALC: one iteration per cycle. Stay while cnt!=7. When cnt==7, go to DONE after that iteration.
  - DONE: done=1 for this cycle. start=1 loads new operands and goes to CALC (back-to-back). Otherwise go to IDLE.
- Iteration (CALC):
  - Adder inputs are P and (Q[0] ? M : 8'h00), with cin=0, giving {c,s}.
  - Register update: {P,Q} <= {c,s,Q} >> 1 (17-bit logical shift right); cnt<=cnt+1.
  - The carry out of the adder must not be dropped. It becomes P[7] after the shift.
- Output:
  - On the CALC->DONE transition, product <= {P_next,Q_next}. It holds through DONE and IDLE.
  - product changes only at this transition or on reset.
- Latency:
  - start accepted at edge k. CALC occupies edges k+1..k+8.
  - done=1 and product valid in the cycle after edge k+8.
  - Total: 9 cycles from the start edge to done. Throughput: one product per 9 cycles with back-to-back start.
- Boundary conditions:
  - start while busy=1: ignored, no effect on operands or counter.
  - a/b changes after acceptance: no effect on the running operation.
  - Max case 255*255 = 16'hFE01: the carry out of the adder is exercised in most iterations.
  - Reset asserted mid-CALC: abort immediately to the reset values. No done pulse.
  - start held high continuously: a new multiply begins from each DONE cycle.
  - busy and done are never high together.

Optional Feature:
- Macro: ZERO_SKIP_EN.
- Defined: if start is accepted with a==0 or b==0, go directly to DONE at the next edge, skipping CALC.
  - done pulses 1 cycle after the start edge; product=16'h0000; busy stays 0.
- Undefined: zero operands take the full 8-iteration path with normal 9-cycle latency. The result is still 16'h0000.

Test Plan:
- Reset: rst_n=0 with a=8'hFF, b=8'hFF, start=1 -> busy=0, done=0, product=16'h0000 throughout reset.
- Basic: a=3, b=5, start for 1 cycle -> busy high 8 cycles, done pulses on the 9th cycle, product=16'd15, then held in IDLE.
- Carry path: a=255, b=255 -> product=16'hFE01. Also a=128, b=2 -> 16'h0100; a=1, b=255 -> 16'h00FF.
- Ignore while busy: start a=10, b=10; at cycle 4 pulse start with a=7, b=7 -> product=16'd100, only one done pulse.
- Back-to-back and abort:
  - start held high with a=2, b=3 then a=4, b=5 loaded at the DONE cycle -> done pulses 9 cycles apart, products 6 then 20.
  - rst_n pulsed low mid-CALC -> no done pulse, product=0.
- Zero operand: a=0, b=200 -> with ZERO_SKIP_EN, done 1 cycle after start and product=0. Without it, done after 9 cycles and product=0.
